qpsk_frame_tx: RTL and testbench

- Transmit-side source for the CMA receive chain. Generates framed, unit-modulus QPSK symbols in the same fixed-point format the equalizer consumes (R^2 = 1.0).
- Frame layout: fixed preamble, then PRBS-7 payload, then an idle gap.
- Output uses a valid/ready stream so a channel model or the equalizer can apply backpressure.

---
 rtl/qpsk_pkg.sv | 31 +++
 rtl/prbs7_gen.sv | 32 +++
 rtl/qpsk_frame_tx.sv | 193 +++++++++++++++++++
 tb/tb_qpsk_frame_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK frame transmitter: FSM states, PRBS-7 taps
// and the elaboration-time QPSK amplitude.
package qpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  // x^7 + x^6 + 1, Fibonacci form: feedback bit = s[6] ^ s[5]
  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;

  // round(2^frac_bits / sqrt(2)) == round(sqrt(2^(2*frac_bits-1))), integer-only
  function automatic int amp(input int frac_bits);
    longint n;
    longint r;
    longint t;
    n = longint'(1) << (2 * frac_bits - 1);
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= n) r = t;
    end
    if (n - r * r > r) r = r + 1;
    return int'(r);
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS-7 generator producing two sequence bits (one QPSK dibit) per advance.
module prbs7_gen
  import qpsk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic [1:0] dibit
);

  logic [6:0] state_q, state_d;
  logic       b0, b1;

  // b1 is the bit the register would produce one shift after b0
  assign b0    = state_q[PRBS_TAP_HI] ^ state_q[PRBS_TAP_LO];
  assign b1    = state_q[PRBS_TAP_HI-1] ^ state_q[PRBS_TAP_LO-1];
  assign dibit = {b1, b0};

  always_comb begin
    state_d = state_q;
    if (load)         state_d = seed;
    else if (advance) state_d = {state_q[4:0], b0, b1};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= seed;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/qpsk_frame_tx.sv
// Framed QPSK symbol source: preamble, PRBS-7 payload, idle gap, on a
// registered valid/ready stream with hold-on-backpressure.
module qpsk_frame_tx
  import qpsk_pkg::*;
#(
  parameter int         DATA_WIDTH   = 16,
  parameter int         FRAC_BITS    = 12,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         PAYLOAD_LEN  = 256,
  parameter int         GAP_LEN      = 8,
  parameter logic [6:0] PRBS_SEED    = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out_real,
  output logic [DATA_WIDTH-1:0] data_out_imag,
  output logic                  data_out_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int CNT_MAX = (PREAMBLE_LEN > PAYLOAD_LEN) ? PREAMBLE_LEN : PAYLOAD_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  localparam logic [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(amp(FRAC_BITS));
  localparam logic [DATA_WIDTH-1:0] AMP_NEG = -AMP_POS;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      sym_cnt_q, sym_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] real_q, real_d;
  logic [DATA_WIDTH-1:0] imag_q, imag_d;
  logic                  fs_q, fs_d;
  logic                  fe_q, fe_d;

  logic       prbs_load, prbs_adv;
  logic [1:0] dibit;
  logic       accept, step, enter_pre, gap_done;

  prbs7_gen u_prbs (
    .clk    (clk),
    .rst    (rst),
    .load   (prbs_load),
    .seed   (PRBS_SEED),
    .advance(prbs_adv),
    .dibit  (dibit)
  );

  assign accept   = valid_q && out_ready;
  // A new symbol is produced once the presented one is gone (accepted now,
  // or accepted earlier while enable was low) and the block is enabled.
  assign step     = enable && (!valid_q || out_ready);
  assign gap_done = (GAP_LEN == 0) || (gap_cnt_q == GAP_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = valid_q;
    real_d      = real_q;
    imag_d      = imag_q;
    fs_d        = fs_q;
    fe_d        = fe_q;
    prbs_load   = 1'b0;
    prbs_adv    = 1'b0;
    enter_pre   = 1'b0;

    case (state_q)
      ST_IDLE: enter_pre = start && enable;

      ST_PREAMBLE: begin
        if (step) begin
          valid_d = 1'b1;
          fs_d    = 1'b0;
          if (sym_cnt_q == PRE_LAST) begin
            state_d   = ST_PAYLOAD;
            sym_cnt_d = '0;
            prbs_adv  = 1'b1;
            real_d    = dibit[0] ? AMP_NEG : AMP_POS;
            imag_d    = dibit[1] ? AMP_NEG : AMP_POS;
            fe_d      = (PAY_LAST == '0);
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            real_d    = sym_cnt_d[0] ? AMP_NEG : AMP_POS;
            imag_d    = real_d;
          end
        end else if (accept) begin
          valid_d = 1'b0;
          fs_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end

      ST_PAYLOAD: begin
        if (step) begin
          if (sym_cnt_q == PAY_LAST) begin
            state_d     = ST_GAP;
            gap_cnt_d   = '0;
            valid_d     = 1'b0;
            fs_d        = 1'b0;
            fe_d        = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            valid_d   = 1'b1;
            sym_cnt_d = sym_cnt_q + 1'b1;
            prbs_adv  = 1'b1;
            real_d    = dibit[0] ? AMP_NEG : AMP_POS;
            imag_d    = dibit[1] ? AMP_NEG : AMP_POS;
            fe_d      = (sym_cnt_d == PAY_LAST);
          end
        end else if (accept) begin
          valid_d = 1'b0;
          fs_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end

      ST_GAP: begin
        if (enable) begin
          if (gap_done) begin
            if (continuous) enter_pre = 1'b1;
            else            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Every frame starts from the seed so payloads repeat frame to frame
    if (enter_pre) begin
      state_d   = ST_PREAMBLE;
      sym_cnt_d = '0;
      prbs_load = 1'b1;
      valid_d   = 1'b1;
      real_d    = AMP_POS;
      imag_d    = AMP_POS;
      fs_d      = 1'b1;
      fe_d      = 1'b0;
    end
  end

  // NOTE: registers use non-blocking assignments so all state updates together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sym_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      real_q      <= '0;
      imag_q      <= '0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
    end
  end

  assign data_out_real  = real_q;
  assign data_out_imag  = imag_q;
  assign data_out_valid = valid_q;
  assign frame_start    = fs_q;
  assign frame_end      = fe_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_qpsk_frame_tx.sv
// Self-checking bench for qpsk_frame_tx: accepted symbols are compared with a
// frame built from the framing rules and the PRBS-7 recurrence.
module tb_qpsk_frame_tx;

  localparam int          PRE   = 32;
  localparam int          PAY   = 256;
  localparam int          FRAME = PRE + PAY;
  localparam logic [15:0] AP    = 16'd2896;
  localparam logic [15:0] AN    = 16'hF4B0;  // -2896

  typedef logic [33:0] sym_t;  // {real, imag, frame_start, frame_end}

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        enable     = 1'b1;
  logic        start      = 1'b0;
  logic        continuous = 1'b0;
  logic        out_ready  = 1'b1;
  logic [15:0] data_out_real;
  logic [15:0] data_out_imag;
  logic        data_out_valid;
  logic        frame_start;
  logic        frame_end;
  logic        busy;
  logic [15:0] frame_count;

  int   errors = 0;
  int   checks = 0;
  sym_t exp_frame[$];
  sym_t acc[$];
  int   valid_cycles;
  int   idle_busy_cycles;

  qpsk_frame_tx dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .start         (start),
    .continuous    (continuous),
    .out_ready     (out_ready),
    .data_out_real (data_out_real),
    .data_out_imag (data_out_imag),
    .data_out_valid(data_out_valid),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: alternating preamble, then dibits from b[n] = b[n-7] ^ b[n-6]
  task automatic build_expected();
    logic [6:0] seed;
    int         h[$];
    logic       b0, b1;
    seed = 7'h7F;
    for (int i = 0; i < 7; i++) h.push_back(int'(seed[6-i]));
    for (int k = 0; k < 2 * PAY; k++) h.push_back(h[k] ^ h[k+1]);
    for (int k = 0; k < PRE; k++)
      exp_frame.push_back({(k % 2 == 1) ? AN : AP, (k % 2 == 1) ? AN : AP, (k == 0), 1'b0});
    for (int j = 0; j < PAY; j++) begin
      b0 = h[7 + 2 * j][0];
      b1 = h[8 + 2 * j][0];
      exp_frame.push_back({b0 ? AN : AP, b1 ? AN : AP, 1'b0, (j == PAY - 1)});
    end
  endtask

  // Stream monitor: records accepts, checks hold/no-drop under backpressure
  initial begin
    logic stall;
    sym_t prev, cur;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = {data_out_real, data_out_imag, frame_start, frame_end};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) check("hold", 64'({data_out_valid, cur}), 64'({1'b1, prev}));
        if (data_out_valid)  valid_cycles++;
        else if (busy)       idle_busy_cycles++;
        if (data_out_valid && out_ready) acc.push_back(cur);
        stall = data_out_valid && !out_ready;
        prev  = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    start      = 1'b0;
    enable     = 1'b1;
    continuous = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    acc.delete();
    valid_cycles     = 0;
    idle_busy_cycles = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 64'(data_out_valid), 64'(0));
    check({tag, "_real"},  64'(data_out_real),  64'(0));
    check({tag, "_imag"},  64'(data_out_imag),  64'(0));
    check({tag, "_fs"},    64'(frame_start),    64'(0));
    check({tag, "_fe"},    64'(frame_end),      64'(0));
    check({tag, "_busy"},  64'(busy),           64'(0));
    check({tag, "_count"}, 64'(frame_count),    64'(0));
  endtask

  task automatic run_until_idle(input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (busy && n < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic check_frames(input string tag, input int nframes);
    int n;
    check({tag, "_len"}, 64'(acc.size()), 64'(nframes * FRAME));
    n = (acc.size() < nframes * FRAME) ? acc.size() : nframes * FRAME;
    for (int i = 0; i < n; i++) check(tag, 64'(acc[i]), 64'(exp_frame[i % FRAME]));
  endtask

  initial begin
    int n;
    int n0;
    build_expected();

    // Reset state, first-symbol latency, full frame at ready=1
    do_reset();
    check_cleared("reset");
    check("pre_start_valid", 64'(data_out_valid), 64'(0));
    pulse_start();
    check("first_valid", 64'(data_out_valid), 64'(1));
    check("first_real",  64'(data_out_real),  64'(AP));
    check("first_imag",  64'(data_out_imag),  64'(AP));
    check("first_fs",    64'(frame_start),    64'(1));
    check("first_busy",  64'(busy),           64'(1));
    tick();
    check("second_real", 64'(data_out_real),  64'(AN));
    check("second_imag", 64'(data_out_imag),  64'(AN));
    check("second_fs",   64'(frame_start),    64'(0));
    run_until_idle(1000, 1'b0);
    check_frames("frame_r1", 1);
    check("valid_cycles", 64'(valid_cycles),     64'(FRAME));
    check("gap_cycles",   64'(idle_busy_cycles), 64'(8));
    check("count_r1",     64'(frame_count),      64'(1));
    check("busy_r1",      64'(busy),             64'(0));

    // Random backpressure
    do_reset();
    pulse_start();
    run_until_idle(4000, 1'b1);
    check_frames("frame_rand", 1);
    check("count_rand", 64'(frame_count), 64'(1));

    // Continuous mode, three frames
    do_reset();
    continuous = 1'b1;
    pulse_start();
    n = 0;
    while (frame_count != 16'd3 && n < 2000) begin
      tick();
      n++;
    end
    check("cont_reach3", 64'(frame_count), 64'(3));
    continuous = 1'b0;
    run_until_idle(100, 1'b0);
    check_frames("frame_cont", 3);
    check("gap_cycles_cont", 64'(idle_busy_cycles), 64'(24));
    check("count_cont",      64'(frame_count),      64'(3));

    // enable low mid-payload, then start pulsed mid-frame
    do_reset();
    pulse_start();
    repeat (100) tick();
    enable = 1'b0;
    n0 = acc.size();
    repeat (10) tick();
    check("en_window_accepts", 64'((acc.size() - n0) <= 1), 64'(1));
    enable = 1'b1;
    repeat (20) tick();
    pulse_start();
    run_until_idle(1000, 1'b0);
    check_frames("frame_en", 1);
    check("count_en", 64'(frame_count), 64'(1));

    // rst mid-payload, then a clean frame
    do_reset();
    pulse_start();
    repeat (80) tick();
    start = 1'b1;
    rst   = 1'b1;
    tick();
    check_cleared("mid_rst");
    rst   = 1'b0;
    start = 1'b0;
    acc.delete();
    tick();
    pulse_start();
    run_until_idle(1000, 1'b0);
    check_frames("frame_after_rst", 1);
    check("count_after_rst", 64'(frame_count), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
